// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bus of the branch predictor: lookup, resolution and statistics.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] fetch_pc;
  logic            predict_taken;
  logic [XLEN-1:0] predict_target;
  logic            update_valid;
  logic [XLEN-1:0] update_pc;
  logic            update_taken;
  logic [XLEN-1:0] update_target;
  logic            update_pred_taken;
  logic [XLEN-1:0] update_pred_target;
  logic            mispredict;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  // Pipeline side: presents fetch PC and resolved branches, consumes predictions.
  modport master (
    output fetch_pc, update_valid, update_pc, update_taken, update_target,
           update_pred_taken, update_pred_target,
    input  predict_taken, predict_target, mispredict, branch_count, mispredict_count
  );

  // Predictor side.
  modport slave (
    input  fetch_pc, update_valid, update_pc, update_taken, update_target,
           update_pred_taken, update_pred_target,
    output predict_taken, predict_target, mispredict, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit saturating-counter direction predictor with branch target buffer.
// Lookup is zero-latency; resolution updates the table at the rising edge and
// flags mispredictions combinationally. Table is held in flops so reset clears it in one cycle.
module branch_predictor #(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = XLEN - INDEX_BITS - 2
) (
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bus
);
  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];

  logic [31:0] branch_count_q;
  logic [31:0] mispredict_count_q;

  logic [INDEX_BITS-1:0] f_idx;
  logic [TAG_BITS-1:0]   f_tag;
  logic                  f_hit;
  logic [INDEX_BITS-1:0] u_idx;
  logic [TAG_BITS-1:0]   u_tag;
  logic                  u_hit;
  logic [XLEN-1:0]       resolved_next;
  logic                  mispredict;

  // Fetch lookup; reset masks the hit so outputs reflect the cleared table immediately.
  always_comb begin
    f_idx              = bus.fetch_pc[INDEX_BITS+1:2];
    f_tag              = bus.fetch_pc[XLEN-1:INDEX_BITS+2];
    f_hit              = !reset && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    bus.predict_taken  = f_hit && ctr_q[f_idx][1];
    bus.predict_target = (f_hit && ctr_q[f_idx][1]) ? target_q[f_idx]
                                                    : bus.fetch_pc + XLEN'(4);
  end

  // Resolution: table hit for the resolving branch and next-PC mismatch detection.
  always_comb begin
    u_idx         = bus.update_pc[INDEX_BITS+1:2];
    u_tag         = bus.update_pc[XLEN-1:INDEX_BITS+2];
    u_hit         = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    resolved_next = bus.update_taken ? bus.update_target : bus.update_pc + XLEN'(4);
    mispredict    = bus.update_valid &&
                    ((bus.update_taken != bus.update_pred_taken) ||
                     (resolved_next != bus.update_pred_target));
  end

  assign bus.mispredict       = mispredict;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

  // Table training: hits move the counter, taken misses allocate, not-taken misses are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '{default: 1'b0};
      tag_q    <= '{default: '0};
      ctr_q    <= '{default: 2'b01};
      target_q <= '{default: '0};
    end else if (bus.update_valid) begin
      if (u_hit) begin
        if (bus.update_taken) begin
          if (ctr_q[u_idx] != 2'b11) ctr_q[u_idx] <= ctr_q[u_idx] + 2'b01;
          target_q[u_idx] <= bus.update_target;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_q[u_idx] <= ctr_q[u_idx] - 2'b01;
        end
      end else if (bus.update_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        ctr_q[u_idx]    <= 2'b10;
        target_q[u_idx] <= bus.update_target;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (bus.update_valid && (branch_count_q != '1))
        branch_count_q <= branch_count_q + 32'd1;
      if (mispredict && (mispredict_count_q != '1))
        mispredict_count_q <= mispredict_count_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared against a table model built from the predictor's behavioural rules.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset;

  branch_predictor_if #(.XLEN(32)) bus ();

  branch_predictor #(.XLEN(32), .INDEX_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: 16 entries, counter kept as a plain integer 0..3.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  int          m_ctr   [16];
  logic [31:0] m_tgt   [16];
  longint      m_bc;
  longint      m_mc;
  localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_ctr[i] = 1; m_tgt[i] = '0;
    end
    m_bc = 0; m_mc = 0;
  endfunction

  function automatic bit model_taken(logic [31:0] pc);
    int idx = int'((pc >> 2) % 16);
    logic [25:0] tag = pc[31:6];
    return m_valid[idx] && (m_tag[idx] == tag) && (m_ctr[idx] >= 2);
  endfunction

  function automatic logic [31:0] model_target(logic [31:0] pc);
    int idx = int'((pc >> 2) % 16);
    return model_taken(pc) ? m_tgt[idx] : pc + 32'd4;
  endfunction

  function automatic bit model_mispredict();
    logic [31:0] nxt = bus.update_taken ? bus.update_target : bus.update_pc + 32'd4;
    return bus.update_valid &&
           ((bus.update_taken != bus.update_pred_taken) || (nxt != bus.update_pred_target));
  endfunction

  function automatic void model_update(logic [31:0] pc, bit taken, logic [31:0] tgt);
    int idx = int'((pc >> 2) % 16);
    logic [25:0] tag = pc[31:6];
    if (m_valid[idx] && m_tag[idx] == tag) begin
      if (taken) begin
        m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
        m_tgt[idx] = tgt;
      end else begin
        m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
      end
    end else if (taken) begin
      m_valid[idx] = 1; m_tag[idx] = tag; m_ctr[idx] = 2; m_tgt[idx] = tgt;
    end
  endfunction

  // One rising edge; the model consumes the inputs that were stable before it.
  task automatic tick();
    bit mis = model_mispredict();
    bit r   = reset;
    bit v   = bus.update_valid;
    logic [31:0] pc = bus.update_pc, tgt = bus.update_target;
    bit tk  = bus.update_taken;
    @(posedge clk);
    if (r) model_clear();
    else begin
      if (v) begin
        model_update(pc, tk, tgt);
        if (m_bc < CNT_MAX) m_bc++;
      end
      if (mis && m_mc < CNT_MAX) m_mc++;
    end
    #1;
  endtask

  task automatic set_update(bit v, logic [31:0] pc, bit tk, logic [31:0] tgt,
                            bit ptk, logic [31:0] ptgt);
    bus.update_valid = v; bus.update_pc = pc; bus.update_taken = tk;
    bus.update_target = tgt; bus.update_pred_taken = ptk; bus.update_pred_target = ptgt;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_update(0, '0, 0, '0, 0, '0);
    bus.fetch_pc = 32'h100;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_total++; if (bus.predict_taken !== 1'b0) $display("FAIL reset_taken got %0b want 0", bus.predict_taken); else n_pass++;
    n_total++; if (bus.predict_target !== 32'h104) $display("FAIL reset_target got %h want 00000104", bus.predict_target); else n_pass++;
    n_total++; if (bus.branch_count !== 32'd0) $display("FAIL reset_bcount got %0d want 0", bus.branch_count); else n_pass++;
    n_total++; if (bus.mispredict_count !== 32'd0) $display("FAIL reset_mcount got %0d want 0", bus.mispredict_count); else n_pass++;
    n_total++; if (bus.mispredict !== 1'b0) $display("FAIL reset_mispredict got %0b want 0", bus.mispredict); else n_pass++;
  endtask

  task automatic test_allocate();
    bus.fetch_pc = 32'h100;
    set_update(1, 32'h100, 1, 32'h80, 0, 32'h104);
    #1;
    n_total++; if (bus.mispredict !== 1'b1) $display("FAIL alloc_mispredict got %0b want 1", bus.mispredict); else n_pass++;
    tick();
    set_update(0, '0, 0, '0, 0, '0);
    #1;
    n_total++; if (bus.predict_taken !== 1'b1) $display("FAIL alloc_taken got %0b want 1", bus.predict_taken); else n_pass++;
    n_total++; if (bus.predict_target !== 32'h80) $display("FAIL alloc_target got %h want 00000080", bus.predict_target); else n_pass++;
    n_total++; if (bus.branch_count !== 32'd1) $display("FAIL alloc_bcount got %0d want 1", bus.branch_count); else n_pass++;
    n_total++; if (bus.mispredict_count !== 32'd1) $display("FAIL alloc_mcount got %0d want 1", bus.mispredict_count); else n_pass++;
  endtask

  task automatic test_hysteresis();
    bus.fetch_pc = 32'h100;
    for (int i = 0; i < 2; i++) begin
      set_update(1, 32'h100, 1, 32'h80, 1, 32'h80);
      #1;
      n_total++; if (bus.mispredict !== 1'b0) $display("FAIL hyst_correct_mispredict got %0b want 0", bus.mispredict); else n_pass++;
      tick();
    end
    set_update(1, 32'h100, 0, 32'h80, 1, 32'h80);
    tick();
    set_update(0, '0, 0, '0, 0, '0);
    #1;
    n_total++; if (bus.predict_taken !== 1'b1) $display("FAIL hyst_one_nt_taken got %0b want 1", bus.predict_taken); else n_pass++;
    n_total++; if (bus.predict_target !== 32'h80) $display("FAIL hyst_one_nt_target got %h want 00000080", bus.predict_target); else n_pass++;
    set_update(1, 32'h100, 0, 32'h80, 1, 32'h80);
    tick();
    set_update(0, '0, 0, '0, 0, '0);
    #1;
    n_total++; if (bus.predict_taken !== 1'b0) $display("FAIL hyst_two_nt_taken got %0b want 0", bus.predict_taken); else n_pass++;
    n_total++; if (bus.predict_target !== 32'h104) $display("FAIL hyst_two_nt_target got %h want 00000104", bus.predict_target); else n_pass++;
    n_total++; if (bus.branch_count !== 32'd5) $display("FAIL hyst_bcount got %0d want 5", bus.branch_count); else n_pass++;
    n_total++; if (bus.mispredict_count !== 32'd3) $display("FAIL hyst_mcount got %0d want 3", bus.mispredict_count); else n_pass++;
  endtask

  task automatic test_alias();
    bus.fetch_pc = 32'h100;
    for (int i = 0; i < 2; i++) begin
      set_update(1, 32'h100, 1, 32'h80, 0, 32'h104);
      tick();
    end
    set_update(1, 32'h140, 0, 32'h300, 0, 32'h144);
    tick();
    set_update(0, '0, 0, '0, 0, '0);
    #1;
    n_total++; if (bus.predict_taken !== 1'b1) $display("FAIL alias_nt_keeps got %0b want 1", bus.predict_taken); else n_pass++;
    n_total++; if (bus.predict_target !== 32'h80) $display("FAIL alias_nt_target got %h want 00000080", bus.predict_target); else n_pass++;
    set_update(1, 32'h140, 1, 32'h200, 0, 32'h144);
    tick();
    set_update(0, '0, 0, '0, 0, '0);
    #1;
    n_total++; if (bus.predict_target !== 32'h104) $display("FAIL alias_evicted_target got %h want 00000104", bus.predict_target); else n_pass++;
    bus.fetch_pc = 32'h140;
    #1;
    n_total++; if (bus.predict_taken !== 1'b1) $display("FAIL alias_new_taken got %0b want 1", bus.predict_taken); else n_pass++;
    n_total++; if (bus.predict_target !== 32'h200) $display("FAIL alias_new_target got %h want 00000200", bus.predict_target); else n_pass++;
  endtask

  task automatic test_same_cycle();
    bus.fetch_pc = 32'h100;
    set_update(1, 32'h100, 1, 32'h80, 1, 32'h84);
    #1;
    n_total++; if (bus.predict_taken !== 1'b0) $display("FAIL same_cycle_taken got %0b want 0", bus.predict_taken); else n_pass++;
    n_total++; if (bus.mispredict !== 1'b1) $display("FAIL wrong_target_mispredict got %0b want 1", bus.mispredict); else n_pass++;
    tick();
    set_update(0, '0, 0, '0, 0, '0);
    #1;
    n_total++; if (bus.predict_taken !== 1'b1) $display("FAIL next_cycle_taken got %0b want 1", bus.predict_taken); else n_pass++;
    n_total++; if (bus.predict_target !== 32'h80) $display("FAIL next_cycle_target got %h want 00000080", bus.predict_target); else n_pass++;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [25:0] tag;
    logic [3:0]  idx;
    logic [1:0]  low;
    case ($urandom_range(0, 3))
      0:       tag = 26'd0;
      1:       tag = 26'd1;
      2:       tag = '1;
      default: tag = 26'($urandom);
    endcase
    idx = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
    low = 2'($urandom);
    return {tag, idx, low};
  endfunction

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc  = rand_pc();
      logic [31:0] tgt = ($urandom_range(0, 1) == 0) ? rand_pc() : $urandom;
      bit          tk  = 1'($urandom);
      bit          ptk;
      logic [31:0] ptgt;
      if ($urandom_range(0, 1) == 0) begin
        ptk = model_taken(pc); ptgt = model_target(pc);
      end else begin
        ptk = 1'($urandom);
        case ($urandom_range(0, 2))
          0:       ptgt = tgt;
          1:       ptgt = pc + 32'd4;
          default: ptgt = $urandom;
        endcase
      end
      bus.fetch_pc = ($urandom_range(0, 1) == 0) ? pc : rand_pc();
      set_update($urandom_range(0, 3) != 0, pc, tk, tgt, ptk, ptgt);
      #1;
      n_total++; if (bus.predict_taken !== model_taken(bus.fetch_pc)) $display("FAIL rand_taken pc=%h got %0b want %0b", bus.fetch_pc, bus.predict_taken, model_taken(bus.fetch_pc)); else n_pass++;
      n_total++; if (bus.predict_target !== model_target(bus.fetch_pc)) $display("FAIL rand_target pc=%h got %h want %h", bus.fetch_pc, bus.predict_target, model_target(bus.fetch_pc)); else n_pass++;
      n_total++; if (bus.mispredict !== model_mispredict()) $display("FAIL rand_mispredict pc=%h got %0b want %0b", pc, bus.mispredict, model_mispredict()); else n_pass++;
      tick();
      n_total++; if (bus.branch_count !== 32'(m_bc)) $display("FAIL rand_bcount got %0d want %0d", bus.branch_count, m_bc); else n_pass++;
      n_total++; if (bus.mispredict_count !== 32'(m_mc)) $display("FAIL rand_mcount got %0d want %0d", bus.mispredict_count, m_mc); else n_pass++;
    end
    bus.fetch_pc = 32'hFFFF_FFFC;
    set_update(0, '0, 0, '0, 0, '0);
    #1;
    n_total++; if (bus.predict_target !== model_target(32'hFFFF_FFFC)) $display("FAIL wrap_target got %h want %h", bus.predict_target, model_target(32'hFFFF_FFFC)); else n_pass++;
  endtask

  task automatic test_mid_reset();
    bus.fetch_pc = 32'h100;
    set_update(1, 32'h100, 1, 32'h80, 0, 32'h104);
    tick();
    set_update(1, 32'h100, 1, 32'h80, 1, 32'h80);
    tick();
    #1;
    n_total++; if (bus.predict_taken !== 1'b1) $display("FAIL pre_reset_trained got %0b want 1", bus.predict_taken); else n_pass++;
    reset = 1'b1;
    set_update(1, 32'h100, 1, 32'h80, 0, 32'h104);
    #1;
    n_total++; if (bus.predict_taken !== 1'b0) $display("FAIL in_reset_taken got %0b want 0", bus.predict_taken); else n_pass++;
    n_total++; if (bus.predict_target !== 32'h104) $display("FAIL in_reset_target got %h want 00000104", bus.predict_target); else n_pass++;
    tick();
    reset = 1'b0;
    set_update(0, '0, 0, '0, 0, '0);
    #1;
    n_total++; if (bus.branch_count !== 32'd0) $display("FAIL mid_reset_bcount got %0d want 0", bus.branch_count); else n_pass++;
    n_total++; if (bus.mispredict_count !== 32'd0) $display("FAIL mid_reset_mcount got %0d want 0", bus.mispredict_count); else n_pass++;
    n_total++; if (bus.predict_taken !== 1'b0) $display("FAIL mid_reset_taken got %0b want 0", bus.predict_taken); else n_pass++;
    n_total++; if (bus.predict_target !== 32'h104) $display("FAIL mid_reset_target got %h want 00000104", bus.predict_target); else n_pass++;
    // Counter back at 2'b01 after reset: one taken update only allocates (2), then predicts.
    set_update(1, 32'h100, 1, 32'h90, 0, 32'h104);
    tick();
    set_update(0, '0, 0, '0, 0, '0);
    #1;
    n_total++; if (bus.predict_target !== 32'h90) $display("FAIL post_reset_alloc_target got %h want 00000090", bus.predict_target); else n_pass++;
  endtask

  initial begin
    model_clear();
    reset = 1'b1;
    bus.fetch_pc = '0;
    set_update(0, '0, 0, '0, 0, '0);
    #1;
    test_reset();
    test_allocate();
    test_hysteresis();
    test_alias();
    test_same_cycle();
    model_clear();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart to the execute-stage branch resolution logic.
- Predicts direction and target for the current fetch PC using a direct-mapped table of 2-bit saturating counters plus a branch target buffer.
- Execute returns the resolved outcome (taken flag and target). This updates the table and flags mispredictions to the pipeline flush logic.
- Keeps saturating statistics counters for branches resolved and mispredicted.

Parameters:
- XLEN, 32, PC/target width in bits.
- INDEX_BITS, 4, log2 of table entries (default 16). Index = pc[INDEX_BITS+1:2].
- TAG_BITS, XLEN-INDEX_BITS-2, tag width. Tag = pc[XLEN-1:INDEX_BITS+2].

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_pc  input  XLEN  PC currently being fetched.
- predict_taken  output  1  predicted direction for fetch_pc (combinational).
- predict_target  output  XLEN  next PC: stored target if predicted taken, else fetch_pc+4.
- update_valid  input  1  execute is resolving a conditional branch this cycle.
- update_pc  input  XLEN  PC of the resolving branch.
- update_taken  input  1  resolved direction (branch decoder result).
- update_target  input  XLEN  computed branch target (pc + B-immediate).
- update_pred_taken  input  1  direction predicted for this branch at fetch (piped down).
- update_pred_target  input  XLEN  next PC predicted at fetch (piped down).
- mispredict  output  1  combinational; resolved next PC differs from predicted next PC.
- branch_count  output  32  saturating count of update_valid cycles.
- mispredict_count  output  32  saturating count of mispredict cycles.

Behaviour:
- Entry contents: valid(1), tag(TAG_BITS), ctr(2), target(XLEN).
- Reset: all valid=0, all ctr=2'b01, all targets=0, branch_count=0, mispredict_count=0.
  - The table must be cleared in one cycle, so it is implemented as flops, not RAM.
  - While reset is high, outputs follow the combinational rules on the cleared table, i.e. predict_taken=0 and predict_target=fetch_pc+4.
  - Updates presented while reset=1 are discarded.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==fetch tag.
  - predict_taken = hit && ctr[idx][1].
  - predict_target = predict_taken ? target[idx] : fetch_pc+4. Addition wraps modulo 2^XLEN.
- Mispredict (combinational, gated by update_valid):
  - resolved_next = update_taken ? update_target : update_pc+4.
  - mispredict = update_valid && (update_taken != update_pred_taken || resolved_next != update_pred_target).
  - mispredict=0 whenever update_valid=0.
- Table update at rising edge when update_valid=1 and reset=0, indexed by update_pc:
  - Hit, taken: ctr = min(ctr+1, 3); target = update_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate/replace the entry. valid=1, tag=update tag, ctr=2'b10, target=update_target.
  - Miss, not taken: no change (no allocation of not-taken branches).
- Aliasing: different PCs with equal index and different tag replace each other, but only on a taken miss.
- Same-cycle lookup and update of the same index: lookup returns pre-update contents. The new contents are visible from the next cycle (no bypass).
- Statistics, updated at each edge with reset=0:
  - branch_count += update_valid.
  - mispredict_count += mispredict.
  - Each holds at 32'hFFFF_FFFF once reached (no wrap).
- fetch_pc/update_pc bits [1:0] are ignored for index and tag.
- No other state. No stalls or handshake back-pressure: update is accepted every cycle it is valid.

Test Plan:
- Reset then fetch_pc=0x100 -> predict_taken=0, predict_target=0x104; counts=0.
- Update pc=0x100 taken target=0x80 (pred 0/0x104) -> mispredict=1 that cycle. Next cycle fetch 0x100 -> predict_taken=1, target=0x80; branch_count=1, mispredict_count=1.
- Saturation/hysteresis on entry 0x100:
  - Two more taken updates -> ctr=3.
  - One not-taken update -> still predicts taken (ctr=2).
  - Second not-taken update -> predict_taken=0, predict_target=0x104.
- Alias: after 0x100 is allocated, update pc=0x140 (same index, INDEX_BITS=4):
  - Not taken -> 0x100 still hits.
  - Taken target=0x200 -> fetch 0x100 now misses (0x104); fetch 0x140 predicts 0x200.
- Same-cycle lookup/update: fetch_pc=0x100 while updating 0x100 to allocate -> that cycle predict_taken=0; following cycle predict_taken=1. Taken with correct direction but wrong target (pred target 0x84, actual 0x80) -> mispredict=1.
- Assert reset for one cycle mid-run with update_valid=1 -> table cleared, update ignored, counts=0; the next fetch of a previously trained PC predicts not taken.
